// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: opcode constants, ALU op encodings and the issue entry shared by decode, issue stage and ALU.
package alu_issue_stage_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000, ALU_SUB   = 5'b00001, ALU_XOR   = 5'b00010, ALU_OR    = 5'b00011,
    ALU_AND    = 5'b00100, ALU_SLL   = 5'b00101, ALU_SRL   = 5'b00110, ALU_SRA   = 5'b00111,
    ALU_SLT    = 5'b01000, ALU_SLTU  = 5'b01001, ALU_ADDI  = 5'b01010, ALU_XORI  = 5'b01011,
    ALU_ORI    = 5'b01100, ALU_ANDI  = 5'b01101, ALU_SLLI  = 5'b01110, ALU_SRLI  = 5'b01111,
    ALU_SRAI   = 5'b10000, ALU_SLTI  = 5'b10001, ALU_SLTIU = 5'b10010, ALU_MUL   = 5'b10011,
    ALU_MULH   = 5'b10100, ALU_MULHSU = 5'b10101, ALU_MULHU = 5'b10110
  } alu_op_e;
  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        illegal;
  } issue_t;
endpackage

// File: rtl/alu_issue_stage_decode.sv
// alu_op_decode: combinational RV32IM ALU-class decode into ALU operands and op code.
module alu_op_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_rs1_val,
  input  logic [31:0] i_rs2_val,
  input  logic [31:0] i_imm,
  input  logic [4:0]  i_rd,
  output issue_t      o_issue
);
  logic [4:0]  w_op;
  logic [31:0] w_b;
  logic        w_legal;
  always_comb begin
    w_op = ALU_ADD;
    w_b = i_rs2_val;
    w_legal = 1'b1;
    if (i_opcode == OPC_OP) begin
      case ({i_funct7, i_funct3})
        {F7_BASE, 3'b000}:   w_op = ALU_ADD;
        {F7_BASE, 3'b001}:   w_op = ALU_SLL;
        {F7_BASE, 3'b010}:   w_op = ALU_SLT;
        {F7_BASE, 3'b011}:   w_op = ALU_SLTU;
        {F7_BASE, 3'b100}:   w_op = ALU_XOR;
        {F7_BASE, 3'b101}:   w_op = ALU_SRL;
        {F7_BASE, 3'b110}:   w_op = ALU_OR;
        {F7_BASE, 3'b111}:   w_op = ALU_AND;
        {F7_ALT, 3'b000}:    w_op = ALU_SUB;
        {F7_ALT, 3'b101}:    w_op = ALU_SRA;
        {F7_MULDIV, 3'b000}: w_op = ALU_MUL;
        {F7_MULDIV, 3'b001}: w_op = ALU_MULH;
        {F7_MULDIV, 3'b010}: w_op = ALU_MULHSU;
        {F7_MULDIV, 3'b011}: w_op = ALU_MULHU;
        default:             w_legal = 1'b0;
      endcase
    end else if (i_opcode == OPC_OP_IMM) begin
      w_b = i_imm;
      case (i_funct3)
        3'b000: w_op = ALU_ADDI;
        3'b010: w_op = ALU_SLTI;
        3'b011: w_op = ALU_SLTIU;
        3'b100: w_op = ALU_XORI;
        3'b110: w_op = ALU_ORI;
        3'b111: w_op = ALU_ANDI;
        3'b001: begin
          w_b = {27'b0, i_imm[4:0]};
          w_op = ALU_SLLI;
          w_legal = i_imm[11:5] == F7_BASE;
        end
        default: begin
          w_b = {27'b0, i_imm[4:0]};
          w_op = i_imm[11:5] == F7_ALT ? ALU_SRAI : ALU_SRLI;
          w_legal = i_imm[11:5] == F7_BASE || i_imm[11:5] == F7_ALT;
        end
      endcase
    end else begin
      w_legal = 1'b0;
    end
  end
  // Illegal encodings present all-zero operands so the ALU sees a harmless ADD 0+0.
  assign o_issue = '{op:      w_legal ? w_op : ALU_ADD,
                     a:       w_legal ? i_rs1_val : 32'b0,
                     b:       w_legal ? w_b : 32'b0,
                     rd:      i_rd,
                     illegal: ~w_legal};
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes one instruction per cycle into a registered output slot backed by a skid entry.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);
  issue_t r_out, r_skid, w_dec;
  logic   r_out_valid, r_skid_full;
  logic   w_accept, w_out_free;
  alu_op_decode u_dec (
    .i_opcode(in_opcode), .i_funct3(in_funct3), .i_funct7(in_funct7),
    .i_rs1_val(in_rs1_val), .i_rs2_val(in_rs2_val), .i_imm(in_imm),
    .i_rd(in_rd), .o_issue(w_dec)
  );
  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready   = ~r_skid_full;
  assign w_accept   = in_valid & in_ready;
  assign w_out_free = ~r_out_valid | out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_out <= '0;
      r_skid <= '0;
      r_out_valid <= 1'b0;
      r_skid_full <= 1'b0;
    end else if (r_skid_full && w_out_free) begin
      r_out <= r_skid;
      r_skid_full <= 1'b0;
    end else if (w_out_free) begin
      r_out_valid <= w_accept;
      if (w_accept) r_out <= w_dec;
    end else if (w_accept) begin
      r_skid <= w_dec;
      r_skid_full <= 1'b1;
    end
  assign out_valid   = r_out_valid;
  assign alu_a       = r_out.a;
  assign alu_b       = r_out.b;
  assign alu_op      = r_out.op;
  assign out_rd      = r_out.rd;
  assign out_illegal = r_out.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table-driven decode vectors plus hand sequences for backpressure, streaming and reset.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_illegal;
  logic [6:0]  in_opcode = '0, in_funct7 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0;
  logic [4:0]  in_rd = '0, alu_op, out_rd;
  logic [31:0] alu_a, alu_b;
  int n_pass = 0, n_tot = 0;
  typedef struct {
    logic [6:0] opc; logic [2:0] f3; logic [6:0] f7;
    logic [31:0] rs1, rs2, imm;
    logic [4:0] op; logic [31:0] a, b; logic ill;
  } vec_t;
  vec_t v[19];
  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .out_rd(out_rd), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic add_r(input logic [31:0] rs1, input logic [4:0] rd);
    in_opcode = 7'b0110011; in_funct3 = 3'b000; in_funct7 = 7'b0;
    in_rs1_val = rs1; in_rs2_val = 32'd1; in_imm = 32'b0; in_rd = rd;
  endtask
  initial begin
    v[0]  = '{7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'h0, 5'b00000, 32'd5, 32'd7, 1'b0};
    v[1]  = '{7'b0110011, 3'b000, 7'b0100000, 32'd10, 32'd3, 32'h0, 5'b00001, 32'd10, 32'd3, 1'b0};
    v[2]  = '{7'b0110011, 3'b101, 7'b0100000, 32'hF0000000, 32'd4, 32'h0, 5'b00111, 32'hF0000000, 32'd4, 1'b0};
    v[3]  = '{7'b0110011, 3'b001, 7'b0100000, 32'd9, 32'd9, 32'h0, 5'b00000, 32'd0, 32'd0, 1'b1};
    v[4]  = '{7'b0110011, 3'b011, 7'b0000001, 32'd6, 32'd7, 32'h0, 5'b10110, 32'd6, 32'd7, 1'b0};
    v[5]  = '{7'b0110011, 3'b100, 7'b0000001, 32'd20, 32'd4, 32'h0, 5'b00000, 32'd0, 32'd0, 1'b1};
    v[6]  = '{7'b0010011, 3'b101, 7'b0000000, 32'h80000000, 32'hDEADBEEF, 32'h405, 5'b10000, 32'h80000000, 32'd5, 1'b0};
    v[7]  = '{7'b0010011, 3'b001, 7'b0000000, 32'd11, 32'hDEADBEEF, 32'h3, 5'b01110, 32'd11, 32'd3, 1'b0};
    v[8]  = '{7'b0010011, 3'b101, 7'b0000000, 32'd12, 32'hDEADBEEF, 32'h1F, 5'b01111, 32'd12, 32'd31, 1'b0};
    v[9]  = '{7'b0010011, 3'b001, 7'b0000000, 32'd13, 32'hDEADBEEF, 32'h403, 5'b00000, 32'd0, 32'd0, 1'b1};
    v[10] = '{7'b0010011, 3'b000, 7'b0000000, 32'd14, 32'hDEADBEEF, 32'hFFFFFFFF, 5'b01010, 32'd14, 32'hFFFFFFFF, 1'b0};
    v[11] = '{7'b0010011, 3'b011, 7'b0000000, 32'd15, 32'hDEADBEEF, 32'h10, 5'b10010, 32'd15, 32'h10, 1'b0};
    v[12] = '{7'b0010011, 3'b010, 7'b0000000, 32'd16, 32'hDEADBEEF, 32'hFFFFF800, 5'b10001, 32'd16, 32'hFFFFF800, 1'b0};
    v[13] = '{7'b0010011, 3'b101, 7'b0000000, 32'd17, 32'hDEADBEEF, 32'h205, 5'b00000, 32'd0, 32'd0, 1'b1};
    v[14] = '{7'b0110111, 3'b000, 7'b0000000, 32'd18, 32'd18, 32'h5, 5'b00000, 32'd0, 32'd0, 1'b1};
    v[15] = '{7'b0110011, 3'b111, 7'b0000000, 32'd19, 32'd20, 32'h0, 5'b00100, 32'd19, 32'd20, 1'b0};
    v[16] = '{7'b0110011, 3'b000, 7'b0000010, 32'd21, 32'd22, 32'h0, 5'b00000, 32'd0, 32'd0, 1'b1};
    v[17] = '{7'b0110011, 3'b110, 7'b0000000, 32'd23, 32'd24, 32'h0, 5'b00011, 32'd23, 32'd24, 1'b0};
    v[18] = '{7'b0110011, 3'b001, 7'b0000001, 32'd25, 32'd26, 32'h0, 5'b10100, 32'd25, 32'd26, 1'b0};
    #2;
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst alu_op", {27'b0, alu_op}, 32'd0);
    check("rst rd/ill", {26'b0, out_rd, out_illegal}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      in_opcode = v[i].opc; in_funct3 = v[i].f3; in_funct7 = v[i].f7;
      in_rs1_val = v[i].rs1; in_rs2_val = v[i].rs2; in_imm = v[i].imm; in_rd = 5'(i + 1);
      in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      check($sformatf("vec%0d valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("vec%0d op", i), {27'b0, alu_op}, {27'b0, v[i].op});
      check($sformatf("vec%0d a", i), alu_a, v[i].a);
      check($sformatf("vec%0d b", i), alu_b, v[i].b);
      check($sformatf("vec%0d ill", i), {31'b0, out_illegal}, {31'b0, v[i].ill});
      check($sformatf("vec%0d rd", i), {27'b0, out_rd}, i + 1);
    end
    @(negedge clk);
    check("idle out_valid", {31'b0, out_valid}, 32'd0);
    // Backpressure: three back-to-back sends into a stalled output.
    out_ready = 1'b0;
    add_r(32'd1, 5'd1); in_valid = 1'b1;
    @(negedge clk);
    check("bp in_ready after 1st", {31'b0, in_ready}, 32'd1);
    add_r(32'd2, 5'd2);
    @(negedge clk);
    check("bp in_ready after 2nd", {31'b0, in_ready}, 32'd0);
    add_r(32'd3, 5'd3);
    @(negedge clk);
    check("bp in_ready held", {31'b0, in_ready}, 32'd0);
    check("bp hold a", alu_a, 32'd1);
    check("bp hold rd", {27'b0, out_rd}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp out2 a", alu_a, 32'd2);
    check("bp out2 valid", {31'b0, out_valid}, 32'd1);
    check("bp in_ready back", {31'b0, in_ready}, 32'd1);
    @(negedge clk); in_valid = 1'b0;
    check("bp out3 a", alu_a, 32'd3);
    check("bp out3 rd", {27'b0, out_rd}, 32'd3);
    @(negedge clk);
    check("bp drained", {31'b0, out_valid}, 32'd0);
    // Streaming: ten instructions with both sides always ready.
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        check($sformatf("stream%0d valid", i - 1), {31'b0, out_valid}, 32'd1);
        check($sformatf("stream%0d a", i - 1), alu_a, 32'd100 + 32'(i - 1));
      end
      check($sformatf("stream in_ready %0d", i), {31'b0, in_ready}, 32'd1);
      if (i < 10) begin add_r(32'd100 + 32'(i), 5'(i)); in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
    end
    check("stream end valid", {31'b0, out_valid}, 32'd0);
    // Reset in the middle of a stall with both entries held.
    out_ready = 1'b0;
    add_r(32'd7, 5'd7); in_valid = 1'b1;
    @(negedge clk); add_r(32'd8, 5'd8);
    @(negedge clk); in_valid = 1'b0;
    check("stall full", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst out_valid", {31'b0, out_valid}, 32'd0);
    check("mid rst in_ready", {31'b0, in_ready}, 32'd1);
    check("mid rst alu_a", alu_a, 32'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("no stale 1", {31'b0, out_valid}, 32'd0);
    add_r(32'd55, 5'd9); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    check("post rst accept valid", {31'b0, out_valid}, 32'd1);
    check("post rst accept a", alu_a, 32'd55);
    @(negedge clk);
    check("no stale 2", {31'b0, out_valid}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have port clk: input, 1 bit; the single clock, rising edge.
REQ-002 SHALL have port rst_n: input, 1 bit; reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid: input, 1; upstream decoded instruction present.
REQ-004 SHALL have port in_ready: output, 1; stage accepts when in_valid&in_ready.
REQ-005 SHALL have inputs in_opcode 7, in_funct3 3, in_funct7 7; instruction fields.
REQ-006 SHALL have inputs in_rs1_val 32, in_rs2_val 32, in_imm 32 (sign-extended); in_rd 5.
REQ-007 SHALL have port out_valid: output, 1; ALU operands valid.
REQ-008 SHALL have port out_ready: input, 1; downstream consumes when out_valid&out_ready.
REQ-009 SHALL have outputs alu_a 32, alu_b 32, alu_op 5; these drive the ALU a/b/alu_op inputs.
REQ-010 SHALL have outputs out_rd 5 and out_illegal 1 (unsupported encoding flag).

Function
REQ-011 SHALL decode opcode 0110011 with funct7 0000000: funct3 000 ADD 00000, 001 SLL 00101, 010 SLT 01000, 011 SLTU 01001, 100 XOR 00010, 101 SRL 00110, 110 OR 00011, 111 AND 00100.
REQ-012 SHALL decode opcode 0110011, funct7 0100000: funct3 000 SUB 00001, 101 SRA 00111; other funct3 illegal.
REQ-013 SHALL decode opcode 0110011, funct7 0000001: funct3 000 MUL 10011, 001 MULH 10100, 010 MULHSU 10101, 011 MULHU 10110; funct3 100-111 (divide) illegal.
REQ-014 SHALL decode opcode 0010011: funct3 000 ADDI 01010, 010 SLTI 10001, 011 SLTIU 10010, 100 XORI 01011, 110 ORI 01100, 111 ANDI 01101.
REQ-015 SHALL decode I-shifts: funct3 001 with imm[11:5]=0000000 SLLI 01110; 101 with imm[11:5]=0000000 SRLI 01111, 0100000 SRAI 10000; else illegal.
REQ-016 SHALL set alu_a=in_rs1_val; alu_b=in_rs2_val for R-type, in_imm for I-type, {27'b0,in_imm[4:0]} for I-shifts.
REQ-017 SHALL, for any other opcode/funct combination, emit alu_op=00000, alu_a=0, alu_b=0, out_illegal=1, out_rd passed through; legal ops emit out_illegal=0.
REQ-018 SHALL register decoded result: accepted at edge N -> out_valid=1 after edge N (latency 1), throughput 1 per cycle.
REQ-019 SHALL hold alu_a/alu_b/alu_op/out_rd/out_illegal stable while out_valid=1 and out_ready=0.
REQ-020 SHALL provide a 2-entry buffer (output register + skid register); in_ready is registered, equals NOT skid_full, no combinational path from out_ready to in_ready.
REQ-021 SHALL, on accept while output stalled, store into skid; skid drains to output on the next out_ready=1 cycle, in order.
REQ-022 SHALL, on simultaneous accept and consume with skid empty, replace output register with new entry, out_valid stays 1.
REQ-023 SHALL ignore input fields when in_valid=0 or in_ready=0; no entry lost or duplicated.

Reset
REQ-024 SHALL, on rst_n low at any time, immediately set out_valid=0, skid empty, in_ready=1, alu_a=0, alu_b=0, alu_op=00000, out_rd=0, out_illegal=0; in-flight entries discarded.
REQ-025 SHALL accept a new instruction on the first rising edge after rst_n deasserts.

Structure
REQ-026 SHALL take alu_op encodings (5-bit constants, names as in REQ-011..015) and opcode constants from a shared package also used by the ALU.
REQ-027 SHALL place decode in a combinational sub-module alu_op_decode; buffering stays in alu_issue_stage.

Verification
REQ-028 SHALL test R ADD: opcode 0110011, f7 0, f3 000, rs1=5, rs2=7 -> next cycle alu_op=00000, a=5, b=7, illegal=0.
REQ-029 SHALL test SRAI: opcode 0010011, f3 101, imm=0x405 -> alu_op=10000, b=5.
REQ-030 SHALL test DIV (f7 0000001, f3 100) -> out_illegal=1, alu_op=00000, a=b=0.
REQ-031 SHALL test backpressure: out_ready=0, send 3 back-to-back -> in_ready drops after 2nd accept; release -> outputs 1,2,3 in order, no loss.
REQ-032 SHALL test streaming: in_valid and out_ready held 1 for 10 instructions -> 10 outputs in 11 cycles, in_ready never 0.
REQ-033 SHALL test reset mid-stall with 2 entries held -> out_valid=0, in_ready=1 immediately, no stale output after release.
